key_evt_sched: RTL and testbench
================================

KEY_EVT_SCHED -- requirements
Module: key_evt_sched

Interface
REQ-001 Parameter KEY_NUM, default 4: number of key event sources; legal range 2..16.
REQ-002 Parameter ID_W, default $clog2(KEY_NUM): width of the event index.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 key_en  input  KEY_NUM  one-cycle debounced press pulses, one bit per key, any combination per cycle.
REQ-006 evt_valid  output  1  an event is offered on evt_id.
REQ-007 evt_id  output  ID_W  index of the offered key.
REQ-008 evt_ready  input  1  consumer accepts; transfer = evt_valid & evt_ready in the same cycle.
REQ-009 ovf  output  1  sticky flag: at least one press was dropped.
REQ-010 ovf_clr  input  1  one-cycle pulse that clears ovf.
REQ-011 busy  output  1  high when any event is pending or offered.

Function
REQ-012 pend[KEY_NUM] SHALL hold one outstanding press per key; key_en[i]=1 sets pend[i] on the next edge.
REQ-013 key_en[i]=1 while pend[i]=1 and pend[i] not cleared that cycle SHALL drop the press and set ovf.
REQ-014 The FSM SHALL have states IDLE and OFFER.
REQ-015 IDLE: evt_valid=0; if pend!=0, grant one key, load evt_id, clear its pend bit, and go to OFFER.
REQ-016 OFFER: evt_valid=1; evt_id and evt_valid SHALL hold stable until transfer.
REQ-017 On transfer in OFFER with pend!=0, grant the next key in the same edge and stay in OFFER, giving back-to-back events with no bubble.
REQ-018 On transfer in OFFER with pend==0, go to IDLE.
REQ-019 Grant SHALL be round-robin: search ascending from last_grant+1, wrapping KEY_NUM-1 -> 0; last_grant updates on every grant.
REQ-020 Latency SHALL be key_en at edge t -> pend set at t+1 -> evt_valid high after edge t+2 when idle.
REQ-021 If key_en[i] arrives in the same cycle that pend[i] is cleared by a grant, the set SHALL win: pend[i]=1 and there is no overflow.
REQ-022 If ovf_clr arrives in the same cycle as a new overflow, ovf SHALL remain 1.
REQ-023 busy SHALL equal (|pend) | evt_valid, registered-derived with no combinational path from inputs.
REQ-024 evt_valid SHALL NOT depend combinationally on evt_ready.

Reset
REQ-025 Asserting rst SHALL force pend=0, state=IDLE, evt_valid=0, evt_id=0, ovf=0, busy=0, and last_grant=KEY_NUM-1, so key 0 has first priority.
REQ-026 rst asserted mid-OFFER SHALL discard the offered event and all pending presses without producing a transfer.
REQ-027 The first grant after rst deasserts SHALL use the REQ-025 priority.

Structure
REQ-028 Package key_pkg SHALL hold the FSM state enum (IDLE, OFFER) and the default KEY_NUM constant.
REQ-029 Round-robin selection SHALL be a sub-module, rr_arbiter (req, last_grant in; gnt_valid, gnt_idx out), purely combinational.
REQ-030 All sequential state SHALL reside in key_evt_sched.

Verification
REQ-031 Single press: KEY_NUM=4, key_en=4'b0100 at cycle 0, evt_ready=1 -> evt_valid=1 with evt_id=2 at cycle 2 for exactly 1 cycle; busy falls at cycle 3.
REQ-032 Round robin: key_en=4'b1111 in one cycle, evt_ready=1 -> evt_id sequence 0,1,2,3 on consecutive cycles with no gaps; then key_en=4'b1001 -> 0,3.
REQ-033 Backpressure and overflow: key_en[1] pulsed, evt_ready=0 for 10 cycles, key_en[3] pulsed twice -> evt_id stays 1 and ovf=1; on release the consumer sees 1 then 3 once; ovf_clr clears ovf.
REQ-034 Set-wins: key_en[0] pulsed in the same cycle key 0 is granted -> key 0 is delivered twice and ovf=0.
REQ-035 Reset mid-operation: rst pulsed while evt_valid=1 and pend=4'b0110 -> all outputs zero next cycle; the next key_en=4'b0010 yields evt_id=1.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and defaults for the key event scheduler.
package key_pkg;

   localparam int unsigned KEY_NUM_DFLT = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

endpackage : key_pkg

// File: rtl/key_evt_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_arbiter #(
   parameter int unsigned KEY_NUM = 4,
   parameter int unsigned ID_W    = $clog2(KEY_NUM)
) (
   input  logic [KEY_NUM-1:0] req,
   input  logic [ID_W-1:0]    last_grant,
   output logic               gnt_valid,
   output logic [ID_W-1:0]    gnt_idx
);

   int unsigned idx;

   // Ascending search starting one past the previous winner.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int unsigned k = 1; k <= KEY_NUM; k++) begin
         idx = 32'(last_grant) + k;
         if (idx >= KEY_NUM) begin
            idx = idx - KEY_NUM;
         end
         if (!gnt_valid && req[ID_W'(idx)]) begin
            gnt_valid = 1'b1;
            gnt_idx   = ID_W'(idx);
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/key_evt_sched.sv
// Collects per-key press pulses and offers them one at a time on a
// valid/ready port, round-robin, with a sticky flag for dropped presses.
module key_evt_sched
   import key_pkg::*;
#(
   parameter int unsigned KEY_NUM = KEY_NUM_DFLT,
   parameter int unsigned ID_W    = $clog2(KEY_NUM)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [KEY_NUM-1:0] key_en,
   output logic               evt_valid,
   output logic [ID_W-1:0]    evt_id,
   input  logic               evt_ready,
   output logic               ovf,
   input  logic               ovf_clr,
   output logic               busy
);

   state_t             state_q, state_d;
   logic [KEY_NUM-1:0] pend_q, pend_d;
   logic [ID_W-1:0]    last_q, last_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic               valid_q, valid_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;

   logic               gnt_valid;
   logic [ID_W-1:0]    gnt_idx;
   logic               grant;
   logic               xfer;
   logic [KEY_NUM-1:0] clr_mask;
   logic               drop;

   rr_arbiter #(
      .KEY_NUM (KEY_NUM),
      .ID_W    (ID_W)
   ) u_arb (
      .req        (pend_q),
      .last_grant (last_q),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx)
   );

   // Next-state: grant/offer sequencing, pending bookkeeping and overflow.
   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      id_d     = id_q;
      last_d   = last_q;
      grant    = 1'b0;
      clr_mask = '0;
      xfer     = valid_q & evt_ready;

      case (state_q)
         IDLE: begin
            grant = gnt_valid;
         end
         OFFER: begin
            if (xfer) begin
               grant = gnt_valid;
               if (!gnt_valid) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase

      if (grant) begin
         state_d  = OFFER;
         valid_d  = 1'b1;
         id_d     = gnt_idx;
         last_d   = gnt_idx;
         clr_mask = KEY_NUM'(1) << gnt_idx;
      end

      // A new press on a key being granted this cycle re-arms it rather than dropping.
      drop   = |(key_en & pend_q & ~clr_mask);
      pend_d = (pend_q & ~clr_mask) | key_en;
      ovf_d  = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
      busy_d = (|pend_d) | valid_d;
   end

   // State registers; last grant resets to the top index so key 0 wins first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         last_q  <= ID_W'(KEY_NUM - 1);
         id_q    <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         last_q  <= last_d;
         id_q    <= id_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
      end
   end

   assign evt_valid = valid_q;
   assign evt_id    = id_q;
   assign ovf       = ovf_q;
   assign busy      = busy_q;

endmodule : key_evt_sched

// File: tb/tb_key_evt_sched.sv
// Bench for key_evt_sched: vector table, corner sequences, random vs model.
module tb_key_evt_sched;

   localparam int unsigned KN = 4;
   localparam int unsigned IW = 2;

   logic          clk;
   logic          rst;
   logic [KN-1:0] key_en;
   logic          evt_valid;
   logic [IW-1:0] evt_id;
   logic          evt_ready;
   logic          ovf;
   logic          ovf_clr;
   logic          busy;

   key_evt_sched #(
      .KEY_NUM (KN),
      .ID_W    (IW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_en    (key_en),
      .evt_valid (evt_valid),
      .evt_id    (evt_id),
      .evt_ready (evt_ready),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int npass;
   int ntotal;

   // Sampled DUT outputs of the current cycle.
   int s_valid, s_id, s_ovf, s_busy;
   int got[$];

   // Reference model: per-key outstanding flags plus the offered event.
   bit m_pend[KN];
   bit m_valid;
   int m_id;
   int m_last;
   bit m_ovf;

   task automatic check(input string nm, input int act, input int exp);
      ntotal++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic void m_reset();
      for (int i = 0; i < KN; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0;
      m_id    = 0;
      m_last  = KN - 1;
      m_ovf   = 1'b0;
   endfunction

   function automatic int m_busy();
      int b;
      b = m_valid;
      for (int i = 0; i < KN; i++) if (m_pend[i]) b = 1;
      return b;
   endfunction

   function automatic void m_step(input logic [KN-1:0] ke, input logic rdy, input logic clr);
      bit xfer;
      bit dropped;
      int g;
      xfer    = m_valid && rdy;
      dropped = 1'b0;
      g       = -1;
      if (!m_valid || xfer) begin
         for (int k = 1; k <= KN; k++) begin
            int j;
            j = (m_last + k) % KN;
            if (g < 0 && m_pend[j]) g = j;
         end
      end
      for (int i = 0; i < KN; i++) begin
         if (ke[i]) begin
            if (m_pend[i] && g != i) dropped = 1'b1;
            m_pend[i] = 1'b1;
         end else if (g == i) begin
            m_pend[i] = 1'b0;
         end
      end
      if (g >= 0) begin
         m_valid = 1'b1;
         m_id    = g;
         m_last  = g;
      end else if (xfer) begin
         m_valid = 1'b0;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
   endfunction

   // One clock cycle: drive, sample at negedge, compare with model, advance.
   task automatic tick(input logic r, input logic [KN-1:0] ke, input logic rdy, input logic clr);
      rst       = r;
      key_en    = ke;
      evt_ready = rdy;
      ovf_clr   = clr;
      if (r) m_reset();
      @(negedge clk);
      s_valid = int'(evt_valid);
      s_id    = int'(evt_id);
      s_ovf   = int'(ovf);
      s_busy  = int'(busy);
      check("mdl_valid", s_valid, int'(m_valid));
      check("mdl_id",    s_id,    m_id);
      check("mdl_ovf",   s_ovf,   int'(m_ovf));
      check("mdl_busy",  s_busy,  m_busy());
      if (s_valid != 0 && rdy) got.push_back(s_id);
      if (!r) m_step(ke, rdy, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic check_got(input string nm, input int exp_q[$]);
      check({nm, "_count"}, got.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++) begin
         if (k < got.size()) check($sformatf("%s_evt%0d", nm, k), got[k], exp_q[k]);
      end
   endtask

   typedef struct {
      logic          r;
      logic [KN-1:0] ke;
      int            ev;
      int            eid;
      int            eovf;
      int            ebusy;
   } vec_t;

   vec_t vecs[16];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      npass     = 0;
      ntotal    = 0;
      rst       = 1'b1;
      key_en    = '0;
      evt_ready = 1'b0;
      ovf_clr   = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;

      // Reset values.
      tick(1'b1, 4'b0000, 1'b1, 1'b0);
      check("rst_valid", s_valid, 0);
      check("rst_id",    s_id,    0);
      check("rst_ovf",   s_ovf,   0);
      check("rst_busy",  s_busy,  0);

      // Single press latency, then round-robin bursts from a fresh reset.
      vecs[0]  = '{1'b0, 4'b0100, 0, 0, 0, 0};
      vecs[1]  = '{1'b0, 4'b0000, 0, 0, 0, 1};
      vecs[2]  = '{1'b0, 4'b0000, 1, 2, 0, 1};
      vecs[3]  = '{1'b0, 4'b0000, 0, 2, 0, 0};
      vecs[4]  = '{1'b1, 4'b0000, 0, 0, 0, 0};
      vecs[5]  = '{1'b0, 4'b1111, 0, 0, 0, 0};
      vecs[6]  = '{1'b0, 4'b0000, 0, 0, 0, 1};
      vecs[7]  = '{1'b0, 4'b0000, 1, 0, 0, 1};
      vecs[8]  = '{1'b0, 4'b0000, 1, 1, 0, 1};
      vecs[9]  = '{1'b0, 4'b0000, 1, 2, 0, 1};
      vecs[10] = '{1'b0, 4'b0000, 1, 3, 0, 1};
      vecs[11] = '{1'b0, 4'b1001, 0, 3, 0, 0};
      vecs[12] = '{1'b0, 4'b0000, 0, 3, 0, 1};
      vecs[13] = '{1'b0, 4'b0000, 1, 0, 0, 1};
      vecs[14] = '{1'b0, 4'b0000, 1, 3, 0, 1};
      vecs[15] = '{1'b0, 4'b0000, 0, 3, 0, 0};
      for (int i = 0; i < 16; i++) begin
         tick(vecs[i].r, vecs[i].ke, 1'b1, 1'b0);
         check($sformatf("vec%0d_valid", i), s_valid, vecs[i].ev);
         check($sformatf("vec%0d_id", i),    s_id,    vecs[i].eid);
         check($sformatf("vec%0d_ovf", i),   s_ovf,   vecs[i].eovf);
         check($sformatf("vec%0d_busy", i),  s_busy,  vecs[i].ebusy);
      end

      // Backpressure with a dropped press on key 3.
      tick(1'b1, 4'b0000, 1'b0, 1'b0);
      tick(1'b0, 4'b0010, 1'b0, 1'b0);
      tick(1'b0, 4'b0000, 1'b0, 1'b0);
      tick(1'b0, 4'b0000, 1'b0, 1'b0);
      tick(1'b0, 4'b1000, 1'b0, 1'b0);
      tick(1'b0, 4'b0000, 1'b0, 1'b0);
      tick(1'b0, 4'b1000, 1'b0, 1'b0);
      repeat (4) tick(1'b0, 4'b0000, 1'b0, 1'b0);
      check("bp_valid", s_valid, 1);
      check("bp_id",    s_id,    1);
      check("bp_ovf",   s_ovf,   1);
      // Clear coinciding with another drop keeps the flag.
      tick(1'b0, 4'b1000, 1'b0, 1'b1);
      got.delete();
      tick(1'b0, 4'b0000, 1'b1, 1'b0);
      check("clr_vs_drop_ovf", s_ovf, 1);
      repeat (4) tick(1'b0, 4'b0000, 1'b1, 1'b0);
      check_got("bp_release", '{1, 3});
      tick(1'b0, 4'b0000, 1'b1, 1'b1);
      tick(1'b0, 4'b0000, 1'b1, 1'b0);
      check("ovf_cleared", s_ovf, 0);

      // Press arriving as the same key is granted is kept.
      tick(1'b1, 4'b0000, 1'b1, 1'b0);
      got.delete();
      tick(1'b0, 4'b0001, 1'b1, 1'b0);
      tick(1'b0, 4'b0001, 1'b1, 1'b0);
      repeat (4) tick(1'b0, 4'b0000, 1'b1, 1'b0);
      check_got("set_wins", '{0, 0});
      check("set_wins_ovf", s_ovf, 0);

      // Reset while an event is offered and others pend.
      tick(1'b1, 4'b0000, 1'b0, 1'b0);
      tick(1'b0, 4'b0111, 1'b0, 1'b0);
      tick(1'b0, 4'b0000, 1'b0, 1'b0);
      tick(1'b0, 4'b0000, 1'b0, 1'b0);
      check("mid_valid", s_valid, 1);
      check("mid_id",    s_id,    0);
      tick(1'b1, 4'b0000, 1'b0, 1'b0);
      check("midrst_valid", s_valid, 0);
      check("midrst_busy",  s_busy,  0);
      got.delete();
      tick(1'b0, 4'b0010, 1'b1, 1'b0);
      check("postrst_valid", s_valid, 0);
      check("postrst_id",    s_id,    0);
      check("postrst_ovf",   s_ovf,   0);
      check("postrst_busy",  s_busy,  0);
      repeat (4) tick(1'b0, 4'b0000, 1'b1, 1'b0);
      check_got("postrst", '{1});

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         tick(($urandom_range(0, 199) == 0),
              KN'($urandom & $urandom),
              ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 19) == 0));
      end

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule : tb_key_evt_sched
